// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares one memory port between the ICache miss path (read only) and the
//   DCache miss/write path. It grants one requester at a time from IDLE,
//   launches the latched transaction on the memory port and routes the
//   response back only to the owner. A response timeout makes sure a stuck
//   memory cannot hang either cache.
//
//   Optional feature macro: MEM_ARB_RR_EN
//     undefined : fixed priority, DCache wins over ICache
//     defined   : round-robin between the two requesters on a tie
//
//   TIMEOUT_CYCLES = 0 disables the timeout.
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic              clk,
    input  logic              reset,

    // ICache read request / response
    input  logic              i_req_valid,
    input  logic [ADDR_W-1:0] i_req_addr,
    output logic              i_resp_valid,
    output logic [DATA_W-1:0] i_resp_data,
    output logic              i_resp_err,

    // DCache read/write request / response
    input  logic              d_req_valid,
    input  logic              d_req_we,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic [DATA_W-1:0] d_req_wdata,
    output logic              d_resp_valid,
    output logic [DATA_W-1:0] d_resp_data,
    output logic              d_resp_err,

    // Memory port
    output logic              mem_req_valid,
    output logic              mem_req_we,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_wdata,
    input  logic              mem_req_ready,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_data,

    output logic              busy
);

    // -------------------------------------------------------------------------
    // Local types and constants
    // -------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    // Owner encoding; reset value 0 means ICache.
    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    // The counter only has to reach TIMEOUT_CYCLES-1.
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
    localparam logic [CNT_W-1:0] TO_LAST =
        (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_e              state_q,  state_d;
    logic                owner_q,  owner_d;
    logic [ADDR_W-1:0]   addr_q,   addr_d;
    logic                we_q,     we_d;
    logic [DATA_W-1:0]   wdata_q,  wdata_d;
    logic [DATA_W-1:0]   rdata_q,  rdata_d;
    logic                err_q,    err_d;
    logic [CNT_W-1:0]    cnt_q,    cnt_d;

    logic                any_req;
    logic                pick_d;     // 1 = DCache wins this arbitration
    logic                to_hit;
    logic [CNT_W-1:0]    cnt_inc;

    assign any_req = i_req_valid | d_req_valid;
    assign to_hit  = TO_EN && (cnt_q == TO_LAST);
    // With the timeout disabled the counter simply holds.
    assign cnt_inc = TO_EN ? (cnt_q + CNT_W'(1)) : cnt_q;

    // -------------------------------------------------------------------------
    // Arbitration
    // -------------------------------------------------------------------------
`ifdef MEM_ARB_RR_EN
    logic last_grant_q, last_grant_d;

    // Round-robin: on a tie the requester that was not granted last wins.
    always_comb begin
        if (i_req_valid && d_req_valid) begin
            pick_d = (last_grant_q == OWN_I);
        end else begin
            pick_d = d_req_valid;
        end
    end

    // Remember who was granted so the next tie goes the other way.
    always_comb begin
        last_grant_d = last_grant_q;
        if (state_q == ST_IDLE && any_req) begin
            last_grant_d = pick_d ? OWN_D : OWN_I;
        end
    end

    // Round-robin history register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q <= OWN_I;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`else
    // Fixed priority: DCache always wins when it is requesting.
    always_comb begin
        pick_d = d_req_valid;
    end
`endif

    // -------------------------------------------------------------------------
    // Next-state and datapath logic
    // -------------------------------------------------------------------------
    // Compute next state, latch the winner's request and capture the response.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d = state_q;
        owner_d = owner_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d = ST_REQ;
                    owner_d = pick_d ? OWN_D : OWN_I;
                    addr_d  = pick_d ? d_req_addr : i_req_addr;
                    // ICache only reads, so its we and wdata are forced to 0.
                    we_d    = pick_d & d_req_we;
                    wdata_d = pick_d ? d_req_wdata : '0;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                end
            end

            ST_REQ: begin
                // A response in REQ is not expected and is ignored.
                if (to_hit) begin
                    state_d = ST_RESP;
                    rdata_d = '0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                    if (mem_req_ready) begin
                        state_d = ST_WAIT;
                    end
                end
            end

            ST_WAIT: begin
                // A real response beats a coincident timeout.
                if (mem_resp_valid) begin
                    state_d = ST_RESP;
                    rdata_d = we_q ? '0 : mem_resp_data;
                    err_d   = 1'b0;
                end else if (to_hit) begin
                    state_d = ST_RESP;
                    rdata_d = '0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            ST_RESP: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any transaction in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            owner_q <= OWN_I;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling
            // pre-edge values, independent of statement order.
            state_q <= state_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // Outputs decode straight from registers, so reset clears them at once.
    always_comb begin
        mem_req_valid = (state_q == ST_REQ);
        mem_req_we    = we_q;
        mem_req_addr  = addr_q;
        mem_req_wdata = wdata_q;
        busy          = (state_q != ST_IDLE);

        i_resp_valid  = (state_q == ST_RESP) && (owner_q == OWN_I);
        d_resp_valid  = (state_q == ST_RESP) && (owner_q == OWN_D);

        // Data and error are held at 0 for the requester that is not answered.
        i_resp_data   = i_resp_valid ? rdata_q : '0;
        i_resp_err    = i_resp_valid & err_q;
        d_resp_data   = d_resp_valid ? rdata_q : '0;
        d_resp_err    = d_resp_valid & err_q;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single instruction/data memory port between the ICache miss path and the DCache miss/write path.
- Grants one requester at a time and launches that requester's transaction on the memory port.
- Returns the memory response only to the granted requester.
- Enforces a response timeout so a stuck memory cannot hang either cache; sits between both caches and the memory model/bus bridge.

Parameters:
- ADDR_W, 32, address width of all request ports.
- DATA_W, 32, data width of read/write data.
- TIMEOUT_CYCLES, 256, cycles allowed from leaving IDLE to mem_resp_valid; 0 disables the timeout.

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- i_req_valid  in  1  ICache read request; held high until i_resp_valid.
- i_req_addr  in  ADDR_W  ICache read address.
- i_resp_valid  out  1  one-cycle response pulse to ICache.
- i_resp_data  out  DATA_W  read data to ICache, valid only with i_resp_valid.
- i_resp_err  out  1  timeout flag, valid only with i_resp_valid.
- d_req_valid  in  1  DCache request; held high until d_resp_valid.
- d_req_we  in  1  1 = write, 0 = read.
- d_req_addr  in  ADDR_W  DCache address.
- d_req_wdata  in  DATA_W  DCache write data.
- d_resp_valid  out  1  one-cycle response pulse to DCache.
- d_resp_data  out  DATA_W  read data to DCache; 0 for writes.
- d_resp_err  out  1  timeout flag, valid only with d_resp_valid.
- mem_req_valid  out  1  request to memory; held until mem_req_ready.
- mem_req_we  out  1  write enable to memory.
- mem_req_addr  out  ADDR_W  latched address to memory.
- mem_req_wdata  out  DATA_W  latched write data to memory.
- mem_req_ready  in  1  memory accepts the request in this cycle.
- mem_resp_valid  in  1  memory response or write acknowledge.
- mem_resp_data  in  DATA_W  memory read data.
- busy  out  1  high in every state except IDLE.

Behaviour:
- States: IDLE, REQ, WAIT, RESP. Reset puts the FSM in IDLE and clears every output, register and the owner flag to 0.
- IDLE:
  - Arbitrates only in this state.
  - If any request is valid, latch the winner's owner, address, we and wdata (I: we=0, wdata=0), then go to REQ.
  - Otherwise stay in IDLE.
- Arbitration, default build: fixed priority, DCache over ICache.
- REQ:
  - mem_req_valid=1; addr, we and wdata come from the latched registers, not the live inputs.
  - If mem_req_ready=1, go to WAIT on the next edge.
- WAIT:
  - On mem_resp_valid=1, capture mem_resp_data (forced to 0 when we=1) and go to RESP.
  - A mem_resp_valid in REQ or IDLE is ignored.
- RESP:
  - Exactly one cycle with the owner's resp_valid=1 and the captured data; the other requester's resp outputs stay 0.
  - Always returns to IDLE.
- Latency: request sampled at edge N gives mem_req_valid in cycle N+1. A memory response sampled at edge M gives resp_valid in cycle M+1.
- There is at least one IDLE cycle between back-to-back transactions. The requester deasserts req_valid on the edge that ends its resp_valid cycle, so it is not re-granted.
- Timeout:
  - A counter clears on leaving IDLE and increments each cycle in REQ/WAIT.
  - If it reaches TIMEOUT_CYCLES-1 without mem_resp_valid, go to RESP with resp_err=1 and resp_data=0. mem_req_valid drops on that edge.
  - If mem_resp_valid and the timeout coincide, the response wins and err=0.
- Changes to live request inputs after the grant have no effect on the transaction in flight.
- Reset mid-transaction: the transaction is dropped, outputs go to 0 asynchronously, and no response is issued after reset release.
- busy=1 in REQ/WAIT/RESP.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- When defined, arbitration is round-robin.
  - A last_grant register, reset to I, is updated on each grant.
  - On simultaneous requests, the requester not granted last wins, so the first tie after reset goes to D, then to I.
  - A single requester is always granted.
- When not defined, fixed DCache priority applies and no last_grant register exists.

Test Plan:
- Single I read: i_req addr 0x0000_0040, memory ready immediately, responds 3 cycles later with 0xDEAD_BEEF -> mem_req_addr=0x40 and we=0; one-cycle i_resp_valid with 0xDEADBEEF and err=0; d_resp_valid stays 0.
- Simultaneous I (0x100) and D read (0x200), default build -> D served first at 0x200, then I at 0x100 after one IDLE cycle. With MEM_ARB_RR_EN, two consecutive ties are granted D then I.
- D write addr 0x80, wdata 0x1234_5678, mem_req_ready low for 4 cycles -> mem_req_valid held with stable addr/wdata for 5 cycles; d_resp_valid with data 0 after the ack.
- TIMEOUT_CYCLES=8 and memory never responds -> i_resp_valid with err=1 and data 0 eight cycles after the grant; FSM back in IDLE; a subsequent request completes normally.
- reset asserted during WAIT -> all outputs 0 in the same cycle; a late mem_resp_valid after release produces no resp_valid.
- Request inputs changed during REQ/WAIT -> mem_req_addr keeps its latched value.
